// File: rtl/simd_inst_queue.sv
// Instruction queue in front of the SIMD decoder: buffers 16-bit words and presents
// the head on a valid/ready handshake, driving a canonical NOP whenever it is empty.
module simd_inst_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] NOP_WORD = 16'h0100
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [15:0]              in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [15:0]              out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Handshake status comes only from the occupancy register, so no input reaches an output.
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign out_inst  = out_valid ? mem_q[rd_ptr_q] : NOP_WORD;
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted as occupied.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= in_inst;
    end

endmodule

// File: tb/tb_simd_inst_queue.sv
// Self-checking bench for simd_inst_queue: a queue of expected words is filled on
// accepted pushes and compared against out_inst on every accepted pop.
module tb_simd_inst_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_inst;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_inst;
    logic        out_ready;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;
    logic [15:0] expQ[$];
    logic [15:0] expWord;

    simd_inst_queue #(.DEPTH(4), .NOP_WORD(16'h0100)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_ready(out_ready),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
        #3;
        tests++;
        if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_inst !== 16'h0100) begin
            fails++;
            $display("[TB] FAIL reset_low: count=%0d in_ready=%b out_valid=%b out_inst=%h, want 0 1 0 0100",
                     count, in_ready, out_valid, out_inst);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        tests++;
        if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_inst !== 16'h0100) begin
            fails++;
            $display("[TB] FAIL reset_idle: count=%0d in_ready=%b out_valid=%b out_inst=%h, want 0 1 0 0100",
                     count, in_ready, out_valid, out_inst);
        end
    endtask

    // Drives one accepted push with out_ready low and records it in the scoreboard.
    task automatic push_word(input logic [15:0] w);
        in_valid = 1'b1; in_inst = w;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL push_ready: in_ready=%b want 1 (word %h)", in_ready, w);
        end
        expQ.push_back(w);
        step();
        in_valid = 1'b0;
    endtask

    // Pops until the scoreboard is empty, within a fixed cycle budget.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 16 && expQ.size() > 0; k++) begin
            expWord = expQ.pop_front();
            tests++;
            if (out_valid !== 1'b1 || out_inst !== expWord) begin
                fails++;
                $display("[TB] FAIL %s_order: out_valid=%b out_inst=%h want 1 %h", tag, out_valid, out_inst, expWord);
            end
            step();
        end
        out_ready = 1'b0;
        tests++;
        if (expQ.size() != 0 || out_valid !== 1'b0 || out_inst !== 16'h0100 || count !== 3'd0) begin
            fails++;
            $display("[TB] FAIL %s_empty: left=%0d out_valid=%b out_inst=%h count=%0d want 0 0 0100 0",
                     tag, expQ.size(), out_valid, out_inst, count);
        end
    endtask

    task automatic test_basic_order();
        push_word(16'h1A05);
        tests++;
        if (out_valid !== 1'b1 || out_inst !== 16'h1A05) begin
            fails++;
            $display("[TB] FAIL first_latency: out_valid=%b out_inst=%h want 1 1a05", out_valid, out_inst);
        end
        push_word(16'h2300);
        push_word(16'h3410);
        tests++;
        if (count !== 3'd3) begin
            fails++;
            $display("[TB] FAIL basic_count: count=%0d want 3", count);
        end
        drain("basic");
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) push_word(16'hA000 + 16'(i));
        tests++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL fill_full: count=%0d in_ready=%b want 4 0", count, in_ready);
        end
        in_valid = 1'b1; in_inst = 16'h5555; out_ready = 1'b1;
        expWord = expQ.pop_front();
        tests++;
        if (out_inst !== expWord) begin
            fails++;
            $display("[TB] FAIL fill_pop: out_inst=%h want %h", out_inst, expWord);
        end
        step();
        tests++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL fill_no_passthru: count=%0d in_ready=%b want 3 1", count, in_ready);
        end
        out_ready = 1'b0;
        expQ.push_back(16'h5555);
        step();
        in_valid = 1'b0;
        tests++;
        if (count !== 3'd4) begin
            fails++;
            $display("[TB] FAIL fill_accept: count=%0d want 4", count);
        end
        drain("fill");
    endtask

    task automatic test_wrap();
        push_word(16'hB0F0);
        push_word(16'hB0F1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_inst = 16'hC000 + 16'(i); out_ready = 1'b1;
            expWord = expQ.pop_front();
            expQ.push_back(16'hC000 + 16'(i));
            tests++;
            if (out_inst !== expWord || in_ready !== 1'b1) begin
                fails++;
                $display("[TB] FAIL wrap_order: out_inst=%h in_ready=%b want %h 1", out_inst, in_ready, expWord);
            end
            step();
            tests++;
            if (count !== 3'd2) begin
                fails++;
                $display("[TB] FAIL wrap_count: count=%0d want 2", count);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        drain("wrap");
    endtask

    task automatic test_flush();
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        flush = 1'b1; in_valid = 1'b1; in_inst = 16'hDEAD; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        expQ.delete();
        tests++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_inst !== 16'h0100 || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL flush_clear: count=%0d out_valid=%b out_inst=%h in_ready=%b want 0 0 0100 1",
                     count, out_valid, out_inst, in_ready);
        end
        push_word(16'h4242);
        tests++;
        if (count !== 3'd1) begin
            fails++;
            $display("[TB] FAIL flush_after: count=%0d want 1", count);
        end
        drain("flush");
    endtask

    task automatic test_async_reset();
        push_word(16'h6001);
        push_word(16'h6002);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_inst !== 16'h0100 || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL async_reset: count=%0d out_valid=%b out_inst=%h in_ready=%b want 0 0 0100 1",
                     count, out_valid, out_inst, in_ready);
        end
        #2;
        rst_n = 1'b1;
        expQ.delete();
        step();
        push_word(16'h7777);
        push_word(16'h8888);
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_fill();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
